// File: rtl/mm_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mm_tile_sequencer_if
// Purpose  : Result stream from the tile sequencer to the partial-sum
//            accumulator: valid/ready handshake, result vector, tile indices
//            and first/last-column flags.
// Revision : 1.0 - initial release
// ============================================================================
interface mm_tile_sequencer_if #(
    parameter int N    = 16,
    parameter int DW   = 32,
    parameter int IDXW = 8
) ();
    logic                out_valid;
    logic                out_ready;
    logic [DW*N-1:0]     out_vector;
    logic [IDXW-1:0]     out_row_idx;
    logic [IDXW-1:0]     out_col_idx;
    logic                out_first;
    logic                out_last;

    // Sequencer side: produces results, consumes ready.
    modport master (
        output out_valid, out_vector, out_row_idx, out_col_idx, out_first, out_last,
        input  out_ready
    );

    // Accumulator side: consumes results, produces ready.
    modport slave (
        input  out_valid, out_vector, out_row_idx, out_col_idx, out_first, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_tile_sequencer
// Purpose  : Walks a ROW_TILES x COL_TILES grid of 16x16 tiles in row-major
//            order. Per tile: request the operands, fire one multiply-array
//            operation, capture the result and hand it downstream tagged with
//            its indices and first/last-column flags.
// Revision : 1.0 - initial release
// ============================================================================
module mm_tile_sequencer #(
    parameter int N       = 16,
    parameter int DW      = 32,
    parameter int IDXW    = 8,
    parameter int TIMEOUT = 1024
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 start,
    input  wire  [IDXW-1:0]     row_tiles,
    input  wire  [IDXW-1:0]     col_tiles,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rd_req,
    output logic [IDXW-1:0]     rd_row_idx,
    output logic [IDXW-1:0]     rd_col_idx,
    input  wire                 rd_valid,
    output logic                mm_input_valid,
    input  wire                 mm_add_valid,
    input  wire  [DW*N-1:0]     mm_vector_output,
    mm_tile_sequencer_if.master res
);

    // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   C_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] C_ONE      = IDXW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_MM = 3'd4,
        S_OUTPUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_rows;
    logic [IDXW-1:0]   r_cols;
    logic [IDXW-1:0]   r_r;
    logic [IDXW-1:0]   r_c;
    logic [TW-1:0]     r_tmo;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_req;
    logic [IDXW-1:0]   r_rd_row;
    logic [IDXW-1:0]   r_rd_col;
    logic              r_iv;
    logic              r_out_valid;
    logic [DW*N-1:0]   r_out_vec;
    logic [IDXW-1:0]   r_out_row;
    logic [IDXW-1:0]   r_out_col;
    logic              r_out_first;
    logic              r_out_last;

    logic              w_last_col;
    logic              w_last_row;
    logic [IDXW-1:0]   w_next_r;
    logic [IDXW-1:0]   w_next_c;

    // Position of the current tile in the grid and the row-major successor.
    always_comb begin
        w_last_col = (r_c == (r_cols - C_ONE));
        w_last_row = (r_r == (r_rows - C_ONE));
        w_next_c   = w_last_col ? '0 : (r_c + C_ONE);
        w_next_r   = w_last_col ? (r_r + C_ONE) : r_r;
    end

    // Main sequencer: state, tile counters, timeout and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_cols      <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_tmo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_iv        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if ((row_tiles != '0) && (col_tiles != '0)) begin
                            r_rows   <= row_tiles;
                            r_cols   <= col_tiles;
                            r_r      <= '0;
                            r_c      <= '0;
                            r_rd_req <= 1'b1;
                            r_rd_row <= '0;
                            r_rd_col <= '0;
                            r_state  <= S_FETCH;
                        end else begin
                            // Empty job: report completion without touching the datapath.
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    r_rd_req <= 1'b0;
                    r_state  <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (rd_valid) begin
                        r_iv    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_iv    <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= S_WAIT_MM;
                end
                S_WAIT_MM: begin
                    if (mm_add_valid) begin
                        r_out_vec   <= mm_vector_output;
                        r_out_row   <= r_r;
                        r_out_col   <= r_c;
                        r_out_first <= (r_c == '0);
                        r_out_last  <= w_last_col;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else if (r_tmo == C_TMO_LAST) begin
                        // Datapath never answered: abandon the job with a sticky error.
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (res.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_r         <= w_next_r;
                        r_c         <= w_next_c;
                        if (w_last_col && w_last_row) begin
                            r_state <= S_DONE;
                        end else begin
                            r_rd_req <= 1'b1;
                            r_rd_row <= w_next_r;
                            r_rd_col <= w_next_c;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign rd_req          = r_rd_req;
    assign rd_row_idx      = r_rd_row;
    assign rd_col_idx      = r_rd_col;
    assign mm_input_valid  = r_iv;
    assign res.out_valid   = r_out_valid;
    assign res.out_vector  = r_out_vec;
    assign res.out_row_idx = r_out_row;
    assign res.out_col_idx = r_out_col;
    assign res.out_first   = r_out_first;
    assign res.out_last    = r_out_last;

endmodule
`default_nettype wire
